// File: rtl/add_seq_ctrl.sv
// Multi-cycle adder that reuses one W_SLICE-bit slice over N_SLICE cycles, LSB slice first.
// Optional subtract mode (extra `sub` input) is enabled by defining ADD_SEQ_SUB_EN.
module add_seq_ctrl #(
    parameter int W_SLICE = 16,
    parameter int N_SLICE = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W_SLICE*N_SLICE-1:0]   a,
    input  logic [W_SLICE*N_SLICE-1:0]   b,
    input  logic                         ci,
`ifdef ADD_SEQ_SUB_EN
    input  logic                         sub,
`endif
    output logic [W_SLICE*N_SLICE-1:0]   sum,
    output logic                         co,
    output logic                         ovf,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int W     = W_SLICE * N_SLICE;
    localparam int IDX_W = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       sum_q, sum_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               co_q, co_d;
    logic               ovf_q, ovf_d;

    logic [W-1:0]       b_eff;
    logic               ci_eff;
    logic [W_SLICE-1:0] slice_a;
    logic [W_SLICE-1:0] slice_b;
    logic [W_SLICE:0]   slice_res;
    logic               msb_cin;

    // Subtraction is a + ~b + 1, so only the latched B and the initial carry change.
`ifdef ADD_SEQ_SUB_EN
    assign b_eff  = sub ? ~b : b;
    assign ci_eff = sub ? 1'b1 : ci;
`else
    assign b_eff  = b;
    assign ci_eff = ci;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        co_d    = co_q;
        ovf_d   = ovf_q;

        slice_a   = a_q[idx_q*W_SLICE +: W_SLICE];
        slice_b   = b_q[idx_q*W_SLICE +: W_SLICE];
        slice_res = {1'b0, slice_a} + {1'b0, slice_b} + {{W_SLICE{1'b0}}, carry_q};
        // Carry into the slice MSB recovered from the sum bit and its two operand bits.
        msb_cin   = slice_a[W_SLICE-1] ^ slice_b[W_SLICE-1] ^ slice_res[W_SLICE-1];

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = ci_eff;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*W_SLICE +: W_SLICE] = slice_res[W_SLICE-1:0];
                carry_d = slice_res[W_SLICE];
                if (idx_q == IDX_LAST) begin
                    co_d    = slice_res[W_SLICE];
                    ovf_d   = msb_cin ^ slice_res[W_SLICE];
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign co        = co_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/add_seq_ctrl.md
ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 The block SHALL have parameter W_SLICE, default 16, adder slice width in bits.
REQ-002 The block SHALL have parameter N_SLICE, default 4, slices per operation; operand width W = W_SLICE*N_SLICE.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid  input  1  operands a, b, ci (and sub) valid.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a new operation.
REQ-007 The block SHALL have port a  input  W  operand A.
REQ-008 The block SHALL have port b  input  W  operand B.
REQ-009 The block SHALL have port ci  input  1  carry-in to the lowest slice.
REQ-010 The block SHALL have port sum  output  W  result.
REQ-011 The block SHALL have port co  output  1  carry-out of the top slice.
REQ-012 The block SHALL have port ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
REQ-013 The block SHALL have port out_valid  output  1  sum, co and ovf valid.
REQ-014 The block SHALL have port out_ready  input  1  consumer accepts the result.

Function
REQ-015 The block SHALL contain one W_SLICE-bit adder slice, reused over N_SLICE cycles per operation, LSB slice first.
REQ-016 The FSM SHALL have states IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE, in_valid=1 SHALL latch a, b and ci (after any sub conditioning, REQ-030), clear the slice index to 0, and move to RUN.
REQ-018 In RUN, each cycle SHALL add slice[idx] of A and B plus the carry register, write the slice result into sum[idx], update the carry register and increment idx.
REQ-019 When idx=N_SLICE-1 completes, the FSM SHALL move to DONE, setting co to the final carry and ovf per REQ-012.
REQ-020 Latency SHALL be exactly N_SLICE cycles from the accept edge to out_valid=1 (4 cycles at defaults).
REQ-021 In DONE, out_valid SHALL be 1; sum, co and ovf SHALL hold stable until out_ready=1.
REQ-022 On DONE with out_ready=1, the FSM SHALL return to IDLE and deassert out_valid on the next edge; it SHALL NOT accept a new operation in that same cycle.
REQ-023 a, b, ci and in_valid SHALL be ignored outside IDLE; changes on them SHALL NOT affect an operation in flight.
REQ-024 Arithmetic SHALL be modulo 2^W; carry out of the top slice SHALL appear only on co.
REQ-025 The intermediate carry SHALL propagate only through the carry register between slice cycles; no combinational path SHALL exist from the a or b inputs to sum.
REQ-026 Back-to-back throughput SHALL be one operation per N_SLICE+2 cycles with out_ready held at 1.

Reset
REQ-027 On rst_n=0, the FSM SHALL go to IDLE asynchronously, with in_ready=1, out_valid=0, sum=0, co=0, ovf=0, idx=0 and the carry register at 0.
REQ-028 A reset asserted during RUN or DONE SHALL abandon the operation with no result delivered.
REQ-029 After rst_n deasserts, the first rising edge with in_valid=1 SHALL be accepted.

Configuration
REQ-030 Macro ADD_SEQ_SUB_EN defined: the block SHALL gain an input sub (1 bit); sub=1 at accept SHALL latch ~b and a forced carry-in of 1 (ci ignored), giving a-b; sub=0 SHALL add as normal.
REQ-031 Macro ADD_SEQ_SUB_EN undefined: the block SHALL have no sub port and SHALL only add.

Verification
REQ-032 Reset, then a=64'h0000_0000_0000_0001, b=64'hFFFF_FFFF_FFFF_FFFF, ci=0 -> after 4 cycles, sum=0, co=1, ovf=0.
REQ-033 a=64'h7FFF_FFFF_FFFF_FFFF, b=1, ci=0 -> sum=64'h8000_0000_0000_0000, co=0, ovf=1.
REQ-034 a=64'h0000_FFFF_0000_FFFF, b=0, ci=1 -> sum=64'h0000_FFFF_0001_0000, with the carry crossing the slice boundary; co=0.
REQ-035 out_ready held at 0 for 5 cycles in DONE -> sum, co and ovf stable and out_valid=1 throughout; in_valid=1 pulses are ignored (in_ready=0).
REQ-036 rst_n pulsed low at RUN idx=2 -> out_valid stays 0 and sum=0; a new operation 5+3 then gives sum=8 after 4 cycles.
REQ-037 With ADD_SEQ_SUB_EN defined: a=5, b=7, sub=1 -> sum=64'hFFFF_FFFF_FFFF_FFFE, co=0, ovf=0.
